// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite bus bundle between the arbiter (master side) and the shared slave.
interface axi_lite_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite slave among NUM_MASTERS req/done
// requesters; exactly one read or write transaction in flight at a time.
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  axi_lite_arbiter_if.master            bus
);

  localparam int          PW   = $clog2(NUM_MASTERS);
  localparam int unsigned NM   = NUM_MASTERS;
  localparam logic [PW-1:0] LAST = PW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW, B, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                aw_pend;
  logic                w_pend;
  logic [1:0]          resp_q;

  logic                any_req;
  logic [PW-1:0]       pick;
  int unsigned         cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  // Round-robin search: first requesting master at or above rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NM) cand = cand - NM;
      if (!any_req && m_req[PW'(cand)]) begin
        any_req = 1'b1;
        pick    = PW'(cand);
      end
    end
  end

  // Mux out the picked master's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (pick == PW'(i)) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_we    = m_we[i];
      end
    end
  end

  // Transaction FSM: grant, run one AXI-Lite transfer, report completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      resp_q  <= '0;
      m_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            rr_ptr  <= (pick == LAST) ? '0 : pick + 1'b1;
            if (sel_we) begin
              state   <= AW;
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
            end else begin
              state <= AR;
            end
          end
        end
        AR: if (bus.s_arready) state <= R;
        R: begin
          if (bus.s_rvalid) begin
            resp_q <= bus.s_rresp;
            if (!we_q) m_rdata <= bus.s_rdata;
            state <= DONE;
          end
        end
        // Address and data channels retire independently; a ready arriving
        // after its own valid has dropped is not counted again.
        AW: begin
          if (aw_pend && bus.s_awready) aw_pend <= 1'b0;
          if (w_pend && bus.s_wready)   w_pend  <= 1'b0;
          if ((!aw_pend || bus.s_awready) && (!w_pend || bus.s_wready))
            state <= B;
        end
        B: begin
          if (bus.s_bvalid) begin
            resp_q <= bus.s_bresp;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse to the granted master only.
  always_comb begin
    m_done = '0;
    if (state == DONE) m_done[grant] = 1'b1;
  end

  assign m_err         = (state == DONE) && (resp_q != 2'b00);
  assign bus.s_araddr  = addr_q;
  assign bus.s_arvalid = (state == AR);
  assign bus.s_rready  = (state == R);
  assign bus.s_awaddr  = addr_q;
  assign bus.s_awvalid = aw_pend;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_wstrb   = '1;
  assign bus.s_wvalid  = w_pend;
  assign bus.s_bready  = (state == B);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: transaction-level reference model with an
// every-cycle compare, a schedule-driven slave, directed and random stimulus.
module tb_axi_lite_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_done;
  logic [DW-1:0]   m_rdata;
  logic            m_err;

  axi_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en = 0;
  bit rand_mode = 0;

  // Slave behaviour for directed tests (fixed) or random.
  bit          cfg_fixed = 1;
  int unsigned cfg_da = 0, cfg_dr = 0, cfg_daw = 0, cfg_dw = 0, cfg_db = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_resp = '0;

  // Model of the transaction in flight; k counts cycles since the grant cycle.
  bit          active = 0;
  int unsigned k, t_dn, t_da, t_dr, t_daw, t_dw, t_db, t_m, t_gm;
  logic        t_we;
  logic [31:0] t_addr, t_wdata, t_rd;
  logic [1:0]  t_resp;
  logic [31:0] exp_rdata = '0;
  int unsigned rr = 0;
  int unsigned g_idx;
  bit          found;
  logic        e_ar, e_r, e_aw, e_w, e_b;
  logic [N-1:0] e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input bit r, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
    m_req[m] = r;
    m_we[m]  = we;
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
  endtask

  task automatic wait_done(input int m, input int limit, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!m_done[m] && lat < limit);
    chk("done_seen", 64'(m_done[m]), 1);
  endtask

  // Compare, random requesters, then advance the model and drive the slave.
  always @(negedge clk) begin
    if (active && k == t_dn && !t_we) exp_rdata = t_rd;
    if (chk_en) begin
      e_ar = active && !t_we && k >= 1 && k <= 1 + t_da;
      e_r  = active && !t_we && k >= 2 + t_da && k <= 2 + t_da + t_dr;
      e_aw = active && t_we && k >= 1 && k <= 1 + t_daw;
      e_w  = active && t_we && k >= 1 && k <= 1 + t_dw;
      e_b  = active && t_we && k >= 2 + t_m && k <= 2 + t_m + t_db;
      e_done = (active && k == t_dn) ? (N'(1) << t_gm) : '0;
      chk("arvalid", 64'(bus.s_arvalid), 64'(e_ar));
      if (e_ar) chk("araddr", 64'(bus.s_araddr), 64'(t_addr));
      chk("rready", 64'(bus.s_rready), 64'(e_r));
      chk("awvalid", 64'(bus.s_awvalid), 64'(e_aw));
      if (e_aw) chk("awaddr", 64'(bus.s_awaddr), 64'(t_addr));
      chk("wvalid", 64'(bus.s_wvalid), 64'(e_w));
      if (e_w) chk("wdata", 64'(bus.s_wdata), 64'(t_wdata));
      chk("wstrb", 64'(bus.s_wstrb), 64'hF);
      chk("bready", 64'(bus.s_bready), 64'(e_b));
      chk("m_done", 64'(m_done), 64'(e_done));
      chk("m_err", 64'(m_err), 64'(active && k == t_dn && t_resp != 2'b00));
      chk("m_rdata", 64'(m_rdata), 64'(exp_rdata));
    end

    if (rand_mode && !reset) begin
      for (int i = 0; i < N; i++) begin
        if (m_done[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
          else m_req[i] = 1'b0;
        end else if (!m_req[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1, 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
        end else if (active && t_gm == i && k >= 1 && $urandom_range(0, 15) == 0) begin
          m_req[i] = 1'b0;
        end
      end
    end

    bus.s_arready = 0; bus.s_rvalid = 0; bus.s_awready = 0; bus.s_wready = 0; bus.s_bvalid = 0;
    bus.s_rdata = $urandom; bus.s_rresp = 2'($urandom); bus.s_bresp = 2'($urandom);
    if (reset) begin
      active = 0;
      rr = 0;
      exp_rdata = '0;
    end else if (active) begin
      if (!t_we) begin
        bus.s_arready = (k == 1 + t_da);
        if (k == 2 + t_da + t_dr) begin
          bus.s_rvalid = 1; bus.s_rdata = t_rd; bus.s_rresp = t_resp;
        end
      end else begin
        bus.s_awready = (k >= 1 + t_daw && k <= 1 + t_m);
        bus.s_wready  = (k >= 1 + t_dw && k <= 1 + t_m);
        if (k == 2 + t_m + t_db) begin
          bus.s_bvalid = 1; bus.s_bresp = t_resp;
        end
      end
      if (k == t_dn) active = 0;
      else k++;
    end else if (m_req != '0) begin
      found = 0;
      g_idx = 0;
      for (int j = 0; j < N; j++) begin
        if (!found && m_req[(rr + j) % N]) begin
          found = 1;
          g_idx = (rr + j) % N;
        end
      end
      t_gm    = g_idx;
      rr      = (g_idx + 1) % N;
      t_we    = m_we[g_idx];
      t_addr  = m_addr[g_idx*AW +: AW];
      t_wdata = m_wdata[g_idx*DW +: DW];
      if (cfg_fixed) begin
        t_da = cfg_da; t_dr = cfg_dr; t_daw = cfg_daw; t_dw = cfg_dw; t_db = cfg_db;
        t_rd = cfg_rdata; t_resp = cfg_resp;
      end else begin
        t_da = $urandom_range(0, 3); t_dr = $urandom_range(0, 3);
        t_daw = $urandom_range(0, 3); t_dw = $urandom_range(0, 3); t_db = $urandom_range(0, 3);
        t_rd = $urandom;
        t_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      t_m  = (t_daw > t_dw) ? t_daw : t_dw;
      t_dn = t_we ? 3 + t_m + t_db : 3 + t_da + t_dr;
      active = 1;
      k = 1;
    end
  end

  int lat, cnt, aw_c, w_c, b_c, d_c, both;
  logic [3:0] ord;
  bit seen_any, first_is_aw, seen_ar, saw_r;
  logic [31:0] first_addr, ar_addr;

  initial begin
    repeat (3) tick();
    chk("rst_m_done", 64'(m_done), 0);
    chk("rst_m_err", 64'(m_err), 0);
    chk("rst_m_rdata", 64'(m_rdata), 0);
    chk("rst_valids", 64'({bus.s_arvalid, bus.s_awvalid, bus.s_wvalid, bus.s_rready, bus.s_bready}), 0);
    reset = 0;
    chk_en = 1;

    // Both masters held requesting: m0 write, m1 read, alternating grants.
    cfg_rdata = 32'h0BAD_F00D;
    set_req(0, 1, 1, 32'h10, 32'h1111_1111);
    set_req(1, 1, 0, 32'h20, 0);
    ord = '0; cnt = 0; both = 0; seen_any = 0; seen_ar = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      tick();
      if (bus.s_arvalid && bus.s_awvalid) both++;
      if (!seen_any && (bus.s_arvalid || bus.s_awvalid)) begin
        seen_any = 1;
        first_is_aw = bus.s_awvalid;
        first_addr = bus.s_awvalid ? bus.s_awaddr : bus.s_araddr;
      end
      if (!seen_ar && bus.s_arvalid) begin
        seen_ar = 1;
        ar_addr = bus.s_araddr;
      end
      if (m_done != '0) begin
        cnt++;
        ord = {ord[2:0], m_done[1]};
        if (cnt == 4) m_req = '0;
      end
    end
    chk("sim_count", 64'(cnt), 4);
    chk("sim_order", 64'(ord), 64'b0101);
    chk("sim_first_is_aw", 64'(first_is_aw), 1);
    chk("sim_first_addr", 64'(first_addr), 32'h10);
    chk("sim_araddr", 64'(ar_addr), 32'h20);
    chk("sim_overlap", 64'(both), 0);
    tick();

    // Zero-wait read, cycle by cycle.
    cfg_rdata = 32'hDEAD_BEEF;
    set_req(0, 1, 0, 32'h100, 0);
    tick();
    chk("rd_arvalid_c1", 64'(bus.s_arvalid), 1);
    chk("rd_araddr_c1", 64'(bus.s_araddr), 32'h100);
    tick();
    chk("rd_rready_c2", 64'(bus.s_rready), 1);
    tick();
    chk("rd_done_c3", 64'(m_done), 64'b01);
    chk("rd_rdata_c3", 64'(m_rdata), 32'hDEAD_BEEF);
    chk("rd_err_c3", 64'(m_err), 0);
    m_req = '0;
    tick();
    chk("rd_done_c4", 64'(m_done), 0);

    // Error response then OKAY.
    cfg_resp = 2'b10;
    set_req(1, 1, 0, 32'h40, 0);
    wait_done(1, 20, lat);
    chk("err_lat", 64'(lat), 3);
    chk("err_flag", 64'(m_err), 1);
    m_req = '0;
    tick();
    chk("err_after", 64'(m_err), 0);
    cfg_resp = 2'b00;
    cfg_rdata = 32'h1234_5678;
    set_req(1, 1, 0, 32'h44, 0);
    wait_done(1, 20, lat);
    chk("ok_flag", 64'(m_err), 0);
    chk("ok_rdata", 64'(m_rdata), 32'h1234_5678);
    m_req = '0;
    tick();

    // Split write: wready immediate, awready two cycles late.
    cfg_daw = 2;
    set_req(0, 1, 1, 32'h80, 32'hCAFE_F00D);
    aw_c = 0; w_c = 0; b_c = 0; d_c = 0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      aw_c += int'(bus.s_awvalid);
      w_c  += int'(bus.s_wvalid);
      b_c  += int'(bus.s_bready);
      if (m_done[0]) begin
        d_c++;
        lat = i;
        m_req = '0;
      end
    end
    chk("split_lat", 64'(lat), 5);
    chk("split_awvalid_cycles", 64'(aw_c), 3);
    chk("split_wvalid_cycles", 64'(w_c), 1);
    chk("split_b_cycles", 64'(b_c), 1);
    chk("split_done_pulses", 64'(d_c), 1);
    cfg_daw = 0;

    // Fairness: m1 continuous, m0 raised during m1's transaction.
    set_req(1, 1, 0, 32'h50, 0);
    ord = '0; cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      tick();
      if (bus.s_arvalid && cnt == 0 && !m_req[0]) set_req(0, 1, 0, 32'h60, 0);
      if (m_done != '0) begin
        cnt++;
        ord = {ord[2:0], m_done[1]};
        if (m_done[0]) m_req[0] = 1'b0;
        if (cnt == 3) m_req = '0;
      end
    end
    chk("fair_count", 64'(cnt), 3);
    chk("fair_order", 64'(ord[2:0]), 64'b101);
    tick();

    // Reset while waiting in R for a response that never comes.
    cfg_dr = 40;
    set_req(0, 1, 0, 32'h30, 0);
    saw_r = 0;
    for (int i = 0; i < 10 && !saw_r; i++) begin
      tick();
      saw_r = bus.s_rready;
    end
    chk("rst_in_r", 64'(saw_r), 1);
    reset = 1;
    m_req = '0;
    tick();
    chk("midrst_rready", 64'(bus.s_rready), 0);
    chk("midrst_arvalid", 64'(bus.s_arvalid), 0);
    chk("midrst_done", 64'(m_done), 0);
    reset = 0;
    cfg_dr = 0;
    cfg_rdata = 32'hA5A5_5A5A;
    set_req(0, 1, 0, 32'h44, 0);
    set_req(1, 1, 0, 32'h48, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (m_done == '0 && lat < 20);
    chk("midrst_first_grant", 64'(m_done), 64'b01);
    m_req[0] = 1'b0;
    wait_done(1, 20, lat);
    chk("midrst_m1_lat", 64'(lat), 4);
    chk("midrst_m1_rdata", 64'(m_rdata), 32'hA5A5_5A5A);
    m_req = '0;
    tick();

    // Random traffic with occasional resets.
    cfg_fixed = 0;
    rand_mode = 1;
    repeat (3) begin
      repeat ($urandom_range(400, 600)) tick();
      reset = 1;
      tick();
      reset = 0;
    end
    repeat (300) tick();
    rand_mode = 0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
